display_scanner: RTL

Time-multiplexed driver for an N-digit 7-segment display. It cycles through the digits at a programmable refresh rate, takes a tear-free snapshot of the digit values once per frame, and blanks leading zeros. It sets the decimal-point position and applies PWM brightness to each digit enable. It sits between the numeric formatting logic and the BCD-to-segment decoder, replacing the static per-digit selector.

---
 rtl/display_pkg.sv | 14 +
 rtl/scan_timer.sv | 66 ++++++
 rtl/display_scanner.sv | 129 ++++++++++++
 3 files changed

// File: rtl/display_pkg.sv
// Shared constants and helpers for the multiplexed 7-segment display scanner.
//   DIGIT_ZERO : digit value treated as a leading zero
//   PWM_LEVELS : number of brightness steps per digit slot
//   digit_w()  : index width needed to address n items
package display_pkg;

    localparam int unsigned DIGIT_ZERO = 0;
    localparam int unsigned PWM_LEVELS = 16;

    function automatic int unsigned digit_w(input int unsigned n);
        return $clog2(n);
    endfunction

endpackage

// File: rtl/scan_timer.sv
// Slot/frame timebase for the display scanner.
// Outputs describe the position the scan will occupy after the coming clock edge so the
// caller can register its outputs in lockstep with the timer.
//   clk        : system clock
//   reset      : synchronous active-high reset; arms the start-of-scan pending state
//   cnt_next   : prescaler value for the next cycle (0..REFRESH_DIV-1)
//   digit_next : digit index for the next cycle (0..NDIGITS-1)
//   slot_wrap  : next cycle is the first cycle of a digit slot
//   frame_wrap : next cycle is the first cycle of a frame (digit 0)
module scan_timer
    import display_pkg::*;
#(
    parameter int unsigned REFRESH_DIV = 1600,
    parameter int unsigned NDIGITS     = 4
) (
    input  logic                             clk,
    input  logic                             reset,
    output logic [$clog2(REFRESH_DIV)-1:0]   cnt_next,
    output logic [digit_w(NDIGITS)-1:0]      digit_next,
    output logic                             slot_wrap,
    output logic                             frame_wrap
);

    localparam int unsigned CW   = $clog2(REFRESH_DIV);
    localparam int unsigned DIGW = digit_w(NDIGITS);

    logic [CW-1:0]   cnt_q;
    logic [DIGW-1:0] digit_q;
    logic            pending_q;

    always_comb begin
        cnt_next   = cnt_q + CW'(1);
        digit_next = digit_q;
        slot_wrap  = 1'b0;
        frame_wrap = 1'b0;
        if (pending_q) begin
            // First edge out of reset starts a fresh frame at digit 0, cnt 0.
            cnt_next   = '0;
            digit_next = '0;
            slot_wrap  = 1'b1;
            frame_wrap = 1'b1;
        end else if (cnt_q == CW'(REFRESH_DIV - 1)) begin
            cnt_next  = '0;
            slot_wrap = 1'b1;
            if (digit_q == DIGW'(NDIGITS - 1)) begin
                digit_next = '0;
                frame_wrap = 1'b1;
            end else begin
                digit_next = digit_q + DIGW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q     <= '0;
            digit_q   <= '0;
            pending_q <= 1'b1;
        end else begin
            cnt_q     <= cnt_next;
            digit_q   <= digit_next;
            pending_q <= 1'b0;
        end
    end

endmodule

// File: rtl/display_scanner.sv
// Time-multiplexed N-digit 7-segment scanner: per-frame snapshot of the digit values,
// leading-zero blanking, decimal point placement and PWM brightness on the digit enable.
//   clk         : system clock
//   reset       : synchronous active-high reset
//   nums        : packed digit values, digit i at nums[i*DW +: DW], digit 0 rightmost
//   dp_sel      : digit showing the decimal point; NDIGITS means none
//   lz_en       : leading-zero blanking enable
//   bright      : brightness 0..15 (duty (bright+1)/16)
//   digit       : active digit index
//   num         : active digit value from the snapshot
//   decimal     : decimal point for the active digit
//   digit_en    : PWM'd drive enable, low for blanked digits
//   frame_start : one-cycle pulse in the first cycle of each frame
module display_scanner
    import display_pkg::*;
#(
    parameter int unsigned NDIGITS     = 4,
    parameter int unsigned REFRESH_DIV = 1600,
    parameter int unsigned DW          = 4
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic [NDIGITS*DW-1:0]             nums,
    input  logic [digit_w(NDIGITS+1)-1:0]     dp_sel,
    input  logic                              lz_en,
    input  logic [3:0]                        bright,
    output logic [digit_w(NDIGITS)-1:0]       digit,
    output logic [DW-1:0]                     num,
    output logic                              decimal,
    output logic                              digit_en,
    output logic                              frame_start
);

    localparam int unsigned DIGW = digit_w(NDIGITS);
    localparam int unsigned DPW  = digit_w(NDIGITS + 1);
    localparam int unsigned CNTW = $clog2(REFRESH_DIV);
    localparam int unsigned THW  = $clog2(REFRESH_DIV + 1);
    localparam int unsigned STEP = REFRESH_DIV / PWM_LEVELS;

    logic [CNTW-1:0] cnt_next;
    logic [DIGW-1:0] digit_next;
    logic            slot_wrap;
    logic            frame_wrap;

    scan_timer #(
        .REFRESH_DIV (REFRESH_DIV),
        .NDIGITS     (NDIGITS)
    ) u_timer (
        .clk        (clk),
        .reset      (reset),
        .cnt_next   (cnt_next),
        .digit_next (digit_next),
        .slot_wrap  (slot_wrap),
        .frame_wrap (frame_wrap)
    );

    // Shadow copies of the inputs; only these drive the outputs within a frame.
    logic [NDIGITS*DW-1:0] sh_nums;
    logic [DPW-1:0]        sh_dp;
    logic                  sh_lz;
    logic [3:0]            sh_bright;

    // On the capture edge the fresh inputs are used directly so the snapshot is already
    // visible in the frame_start cycle.
    logic [NDIGITS*DW-1:0] eff_nums;
    logic [DPW-1:0]        eff_dp;
    logic                  eff_lz;
    logic [3:0]            eff_bright;

    assign eff_nums   = frame_wrap ? nums   : sh_nums;
    assign eff_dp     = frame_wrap ? dp_sel : sh_dp;
    assign eff_lz     = frame_wrap ? lz_en  : sh_lz;
    assign eff_bright = frame_wrap ? bright : sh_bright;

    logic [NDIGITS-1:0] blank_vec;

    always_comb begin
        logic above_zero;
        above_zero = 1'b1;
        blank_vec  = '0;
        // Walk from the most significant digit down; a digit is a leading zero only while
        // every digit above it (and itself) is zero. Digit 0 and the dp digit and below
        // always stay lit.
        for (int i = NDIGITS - 1; i >= 0; i--) begin
            above_zero   = above_zero && (eff_nums[i*DW +: DW] == DW'(DIGIT_ZERO));
            blank_vec[i] = eff_lz && above_zero && (i > 0) &&
                           ((int'(eff_dp) >= int'(NDIGITS)) || (i > int'(eff_dp)));
        end
    end

    logic [THW-1:0] pwm_thresh;
    logic [DW-1:0]  num_d;
    logic           decimal_d;
    logic           digit_en_d;

    assign pwm_thresh = THW'((32'(eff_bright) + 32'd1) * STEP);
    assign num_d      = eff_nums[digit_next*DW +: DW];
    assign decimal_d  = (eff_dp == DPW'(digit_next));
    assign digit_en_d = !blank_vec[digit_next] && (THW'(cnt_next) < pwm_thresh);

    always_ff @(posedge clk) begin
        if (reset) begin
            sh_nums     <= '0;
            sh_dp       <= DPW'(NDIGITS);
            sh_lz       <= 1'b0;
            sh_bright   <= '0;
            digit       <= '0;
            num         <= '0;
            decimal     <= 1'b0;
            digit_en    <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            if (frame_wrap) begin
                sh_nums   <= nums;
                sh_dp     <= dp_sel;
                sh_lz     <= lz_en;
                sh_bright <= bright;
            end
            if (slot_wrap) begin
                digit   <= digit_next;
                num     <= num_d;
                decimal <= decimal_d;
            end
            digit_en    <= digit_en_d;
            frame_start <= frame_wrap;
        end
    end

endmodule
